// File: rtl/fifo_pkg.sv
// Shared FIFO constants: read-mode encodings and the default geometry used by
// both the single-clock and the dual-clock FIFO families.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  localparam int FIFO_DEF_WIDTH          = 8;
  localparam int FIFO_DEF_DEPTH          = 16;
  localparam int FIFO_DEF_ADDR_PTR_WIDTH = 4;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH simple dual-port storage: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifo_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered occupancy count, almost-full/almost-empty
// flags, error pulses and selectable standard or first-word-fall-through reads.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH          = FIFO_DEF_WIDTH,
  parameter int DEPTH          = FIFO_DEF_DEPTH,
  parameter int ADDR_PTR_WIDTH = FIFO_DEF_ADDR_PTR_WIDTH,
  parameter int AF_LEVEL       = 12,
  parameter int AE_LEVEL       = 4,
  parameter int FWFT           = FIFO_MODE_STD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        w_data,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        r_data,
  output logic                    r_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [ADDR_PTR_WIDTH:0] count,
  output logic                    wr_err,
  output logic                    rd_err
);

  localparam int PW = ADDR_PTR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);
  localparam logic [PW-1:0] ONE_C   = PW'(1);

  if (DEPTH != 2 ** ADDR_PTR_WIDTH) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must equal 2**ADDR_PTR_WIDTH");
  end
  if (DEPTH < 4) begin : g_small_depth
    $error("sync_fifo_flags: DEPTH must be at least 4");
  end
  if (!(AE_LEVEL >= 0 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
    $error("sync_fifo_flags: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end
  if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
    $error("sync_fifo_flags: FWFT must be 0 or 1");
  end

  logic [PW-1:0]    wr_ptr, rd_ptr, count_q, count_next;
  logic             full_q, empty_q, af_q, ae_q;
  logic             wr_err_q, rd_err_q;
  logic             wr_ok, rd_ok;
  logic [WIDTH-1:0] mem_rdata;

  // Handshake: a write is taken on an edge where wr_en=1 and full=0; a read is
  // taken where rd_en=1 and empty=0. Both flags are the registered values seen
  // before the edge, so there is no bypass between the two sides.
  always_comb begin
    wr_ok      = wr_en && !full_q;
    rd_ok      = rd_en && !empty_q;
    count_next = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_q + ONE_C;
      2'b01:   count_next = count_q - ONE_C;
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ONE_C;
      if (rd_ok) rd_ptr <= rd_ptr + ONE_C;
      count_q  <= count_next;
      full_q   <= (count_next == DEPTH_C);
      empty_q  <= (count_next == '0);
      af_q     <= (count_next >= AF_C);
      ae_q     <= (count_next <= AE_C);
      wr_err_q <= wr_en && full_q;
      rd_err_q <= rd_en && empty_q;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_PTR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_ok),
    .waddr(wr_ptr[ADDR_PTR_WIDTH-1:0]),
    .wdata(w_data),
    .raddr(rd_ptr[ADDR_PTR_WIDTH-1:0]),
    .rdata(mem_rdata)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Head word is shown directly; masked while empty so stale memory never leaks.
    assign r_data  = empty_q ? '0 : mem_rdata;
    assign r_valid = !empty_q;
  end else begin : g_std
    logic [WIDTH-1:0] r_data_q;
    logic             r_valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_data_q  <= '0;
        r_valid_q <= 1'b0;
      end else begin
        r_valid_q <= rd_ok;
        if (rd_ok) r_data_q <= mem_rdata;
      end
    end

    assign r_data  = r_data_q;
    assign r_valid = r_valid_q;
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign wr_err       = wr_err_q;
  assign rd_err       = rd_err_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: table-driven fill/drain vectors on a standard-mode
// instance plus hand-written wrap, reset and FWFT sequences.
module tb_sync_fifo_flags;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         wr_en = 1'b0, rd_en = 1'b0;
  logic [W-1:0] w_data = '0;
  logic [W-1:0] r_data;
  logic         r_valid, full, empty, almost_full, almost_empty, wr_err, rd_err;
  logic [4:0]   count;

  logic         f_wr_en = 1'b0, f_rd_en = 1'b0;
  logic [W-1:0] f_w_data = '0;
  logic [W-1:0] f_r_data;
  logic         f_r_valid, f_full, f_empty, f_af, f_ae, f_wr_err, f_rd_err;
  logic [4:0]   f_count;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         wr_en;
    logic         rd_en;
    logic [W-1:0] w_data;
    int           count;
    logic         wr_err;
    logic         rd_err;
    logic         r_valid;
    logic         chk_data;
    logic [W-1:0] r_data;
  } vec_t;

  vec_t vecs[$];

  sync_fifo_flags #(.FWFT(0)) dut_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .w_data(w_data), .rd_en(rd_en),
    .r_data(r_data), .r_valid(r_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .wr_err(wr_err), .rd_err(rd_err)
  );

  sync_fifo_flags #(.FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .wr_en(f_wr_en), .w_data(f_w_data), .rd_en(f_rd_en),
    .r_data(f_r_data), .r_valid(f_r_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .wr_err(f_wr_err), .rd_err(f_rd_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // flags expected for a given occupancy (AF_LEVEL=12, AE_LEVEL=4, DEPTH=16)
  task automatic check_std_flags(input string tag, input int c);
    check({tag, " count"}, 32'(count), 32'(c));
    check({tag, " full"}, 32'(full), 32'(c == 16));
    check({tag, " empty"}, 32'(empty), 32'(c == 0));
    check({tag, " almost_full"}, 32'(almost_full), 32'(c >= 12));
    check({tag, " almost_empty"}, 32'(almost_empty), 32'(c <= 4));
  endtask

  function automatic vec_t mk(input logic we, input logic re, input logic [W-1:0] wd,
                              input int c, input logic we_err, input logic re_err,
                              input logic rv, input logic cd, input logic [W-1:0] rd);
    vec_t v;
    v.wr_en = we; v.rd_en = re; v.w_data = wd; v.count = c;
    v.wr_err = we_err; v.rd_err = re_err; v.r_valid = rv;
    v.chk_data = cd; v.r_data = rd;
    return v;
  endfunction

  // driver tasks
  task automatic drive(input logic we, input logic re, input logic [W-1:0] wd);
    wr_en = we; rd_en = re; w_data = wd;
    step();
  endtask

  task automatic drive_f(input logic we, input logic re, input logic [W-1:0] wd);
    f_wr_en = we; f_rd_en = re; f_w_data = wd;
    step();
  endtask

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] e;

    // fill: 16 writes, one rejected write, one idle cycle
    for (int i = 0; i < 16; i++) vecs.push_back(mk(1, 0, W'(i), i + 1, 0, 0, 0, 0, '0));
    vecs.push_back(mk(1, 0, 8'hAA, 16, 1, 0, 0, 0, '0));
    vecs.push_back(mk(0, 0, 8'h00, 16, 0, 0, 0, 0, '0));
    // drain: 16 reads, one rejected read, one idle cycle
    for (int j = 0; j < 16; j++) vecs.push_back(mk(0, 1, '0, 15 - j, 0, 0, 1, 1, W'(j)));
    vecs.push_back(mk(0, 1, 8'h00, 0, 0, 1, 0, 1, 8'h0F));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 8'h0F));

    // reset then idle
    rst = 1'b1;
    step();
    step();
    check_std_flags("reset", 0);
    check("reset r_valid", 32'(r_valid), 0);
    check("reset r_data", 32'(r_data), 0);
    check("reset wr_err", 32'(wr_err), 0);
    check("reset rd_err", 32'(rd_err), 0);
    check("reset f_r_valid", 32'(f_r_valid), 0);
    check("reset f_empty", 32'(f_empty), 1);
    rst = 1'b0;
    step();
    check_std_flags("idle", 0);

    // FWFT: word falls through without rd_en, pop empties the FIFO
    drive_f(1, 0, 8'h5A);
    f_wr_en = 1'b0;
    check("fwft r_valid after write", 32'(f_r_valid), 1);
    check("fwft r_data after write", 32'(f_r_data), 32'h5A);
    check("fwft count after write", 32'(f_count), 1);
    step();
    check("fwft r_valid held", 32'(f_r_valid), 1);
    check("fwft r_data held", 32'(f_r_data), 32'h5A);
    drive_f(0, 1, 8'h00);
    f_rd_en = 1'b0;
    check("fwft r_valid after pop", 32'(f_r_valid), 0);
    check("fwft empty after pop", 32'(f_empty), 1);
    check("fwft rd_err after pop", 32'(f_rd_err), 0);
    drive_f(1, 0, 8'h11);
    drive_f(1, 0, 8'h22);
    check("fwft head first", 32'(f_r_data), 32'h11);
    drive_f(0, 1, 8'h00);
    check("fwft head second", 32'(f_r_data), 32'h22);
    drive_f(0, 1, 8'h00);
    check("fwft drained", 32'(f_empty), 1);
    drive_f(0, 1, 8'h00);
    check("fwft rd_err pulse", 32'(f_rd_err), 1);
    drive_f(0, 0, 8'h00);
    check("fwft rd_err clears", 32'(f_rd_err), 0);

    // table-driven fill / drain on the standard instance
    foreach (vecs[k]) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      drive(vecs[k].wr_en, vecs[k].rd_en, vecs[k].w_data);
      check_std_flags(tag, vecs[k].count);
      check({tag, " wr_err"}, 32'(wr_err), 32'(vecs[k].wr_err));
      check({tag, " rd_err"}, 32'(rd_err), 32'(vecs[k].rd_err));
      check({tag, " r_valid"}, 32'(r_valid), 32'(vecs[k].r_valid));
      if (vecs[k].chk_data) check({tag, " r_data"}, 32'(r_data), 32'(vecs[k].r_data));
    end

    // wrap: hold count at 8 with simultaneous read/write across the pointer wrap
    d = 8'h40;
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, d);
      exp_q.push_back(d);
      d++;
    end
    check_std_flags("wrap prefill", 8);
    for (int i = 0; i < 40; i++) begin
      drive(1, 1, d);
      e = exp_q.pop_front();
      exp_q.push_back(d);
      d++;
      check($sformatf("wrap%0d count", i), 32'(count), 8);
      check($sformatf("wrap%0d r_valid", i), 32'(r_valid), 1);
      check($sformatf("wrap%0d r_data", i), 32'(r_data), 32'(e));
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 8'h00);
      e = exp_q.pop_front();
      check($sformatf("wrap drain%0d r_data", i), 32'(r_data), 32'(e));
    end
    drive(0, 0, 8'h00);
    check_std_flags("wrap end", 0);
    check("wrap end r_valid", 32'(r_valid), 0);

    // reset mid-operation with wr_en/rd_en both high
    for (int i = 0; i < 10; i++) drive(1, 0, 8'hC0 + W'(i));
    check_std_flags("pre-reset", 10);
    rst = 1'b1;
    drive(1, 1, 8'hEE);
    rst = 1'b0;
    check_std_flags("mid reset", 0);
    check("mid reset r_valid", 32'(r_valid), 0);
    check("mid reset r_data", 32'(r_data), 0);
    check("mid reset wr_err", 32'(wr_err), 0);
    check("mid reset rd_err", 32'(rd_err), 0);
    drive(0, 0, 8'h00);
    check_std_flags("post reset", 0);
    check("post reset r_valid", 32'(r_valid), 0);
    drive(1, 0, 8'h33);
    drive(0, 1, 8'h00);
    check("post reset r_data", 32'(r_data), 32'h33);
    check("post reset r_valid read", 32'(r_valid), 1);
    drive(0, 0, 8'h00);
    check_std_flags("post reset end", 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Single-clock, parametrised FIFO that succeeds the team's dual-clock gray-code FIFO for paths where both sides share one clock domain. Adds occupancy count, programmable almost-full/almost-empty flags, a selectable first-word-fall-through (FWFT) read mode and a read-valid qualifier. Used as the general buffering primitive between pipeline stages and peripheral datapaths.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; must equal 2**ADDR_PTR_WIDTH, >=4
ADDR_PTR_WIDTH, 4, memory address width
AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL; requires AE_LEVEL < AF_LEVEL <= DEPTH
AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL; requires AE_LEVEL >= 0
FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through

Ports:
clk  input  1  single clock; all state on rising edge
rst  input  1  synchronous reset, active-high
wr_en  input  1  write request
w_data  input  WIDTH  write data
rd_en  input  1  read request (pop/acknowledge in FWFT mode)
r_data  output  WIDTH  read data
r_valid  output  1  r_data holds a valid popped/head word
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  ADDR_PTR_WIDTH+1  current occupancy, 0..DEPTH
wr_err  output  1  one-cycle pulse: write attempted while full
rd_err  output  1  one-cycle pulse: read attempted while empty

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high, overriding all other inputs in the same cycle, including wr_en/rd_en.
- Reset values: wr/rd pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0 (unless AF_LEVEL == 0, illegal), r_data 0, r_valid 0, wr_err 0, rd_err 0. Memory contents are not cleared.
- Pointers: ADDR_PTR_WIDTH+1 bits binary; low bits address memory, MSB is wrap bit. Pointer increments wrap naturally from DEPTH-1 to 0 with MSB toggle.
- Write accepted iff wr_en && !full (full sampled before the edge). Accepted: mem[wr_ptr] <= w_data, wr_ptr++. Rejected: memory and pointer unchanged, wr_err = 1 for the following cycle.
- Read accepted iff rd_en && !empty (empty sampled before the edge). Rejected: rd_err = 1 for the following cycle, pointer unchanged.
- No write-through bypass: write to full FIFO with simultaneous read is rejected; read from empty FIFO with simultaneous write is rejected.
- Simultaneous accepted read and write: count unchanged, both pointers advance.
- count, full, empty, almost_full, almost_empty are registered and always mutually consistent with the pointer state after each edge.
- Standard mode (FWFT=0): on accepted read, r_data <= mem[rd_ptr] at that edge; r_valid = 1 for exactly the following cycle, else 0; r_data holds its last value when no read is accepted. Latency write->readable: word written at edge N can be read by rd_en asserted in cycle after N.
- FWFT mode (FWFT=1): r_data continuously presents mem[rd_ptr]; r_valid = !empty; rd_en with r_valid pops the head, next word appears the cycle after the edge. A word written at edge N is on r_data with r_valid=1 in the cycle after edge N when FIFO was empty.
- Errors are pulses, not sticky; both may assert in the same cycle only if wr_en && rd_en && full && empty, which cannot occur (DEPTH >= 4).

Decomposition:
- Shared package fifo_pkg: constants FIFO_MODE_STD = 0, FIFO_MODE_FWFT = 1; default WIDTH/DEPTH/ADDR_PTR_WIDTH values shared with the async FIFO.
- Sub-module fifo_mem: DEPTH x WIDTH simple dual-port array, synchronous write, asynchronous read; top level adds the output register in standard mode.
- Elaboration-time checks on DEPTH == 2**ADDR_PTR_WIDTH and AE_LEVEL < AF_LEVEL <= DEPTH.

Test Plan:
- Reset then idle: rst=1 two cycles -> count=0, empty=1, almost_empty=1, full=0, r_valid=0, wr_err=rd_err=0.
- Fill (FWFT=0, DEPTH=16): write 0x00..0x0F on consecutive cycles -> almost_full rises after 12th write, full=1 and count=16 after 16th; 17th write (0xAA) -> wr_err pulse one cycle, count stays 16.
- Drain (FWFT=0): 16 reads -> r_data 0x00..0x0F each with r_valid one cycle after its read; almost_empty rises at count=4; 17th read -> rd_err pulse, r_data holds 0x0F.
- Wrap and simultaneous: keep count=8 while doing 40 cycles of simultaneous read/write with incrementing data -> count constant 8, output sequence strictly in order across pointer wrap.
- FWFT=1: write 0x5A into empty FIFO -> next cycle r_data=0x5A, r_valid=1 without rd_en; rd_en -> r_valid=0, empty=1 following cycle.
- Reset mid-operation: count=10, assert rst with wr_en=rd_en=1 -> next cycle count=0, empty=1, no write/read effect, no error pulses.
